stream_demux_1ton: RTL and testbench

//   Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshake on every port.

---
 rtl/stream_demux_pkg.sv | 27 ++
 rtl/stream_demux_1ton_slot.sv | 61 ++++++
 rtl/stream_demux_1ton.sv | 147 ++++++++++++++
 tb/tb_stream_demux_1ton.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// ---------------------------------------------------------------------------
// stream_demux_pkg
//
// Purpose:
//   Shared definitions for the 1-to-N stream demultiplexer: the select FSM
//   state encodings, the drop counter width and a saturating increment
//   helper used by the drop counter.
//
// Contents:
//   ST_IDLE / ST_LOCKED  select FSM state encodings (1 bit)
//   DROP_CNT_W           width of the discarded-beat counter
//   sat_inc()            increment that sticks at all-ones
// ---------------------------------------------------------------------------
package stream_demux_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam int DROP_CNT_W = 16;

    // The drop counter is a diagnostic: once it tops out it must stay at
    // all-ones rather than wrap back to a small, misleading value.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/stream_demux_1ton_slot.sv
// ---------------------------------------------------------------------------
// demux_out_slot
//
// Purpose:
//   One-entry output register for a single demux channel. Holds a beat
//   (data + last flag) until the consumer takes it. A load in the same
//   cycle as a drain wins, so the slot stays full and the channel sustains
//   one beat per clock.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset, empties the slot
//   load       write load_data/load_last into the slot this cycle
//   load_data  payload to store
//   load_last  packet-last flag to store
//   out_ready  consumer ready for this channel
//   out_valid  slot holds a beat
//   out_data   stored payload, stable while out_valid & ~out_ready
//   out_last   stored last flag, stable while out_valid & ~out_ready
// ---------------------------------------------------------------------------
module demux_out_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    // Occupancy flag. A load always leaves the slot full, even if the old
    // beat drains on the same edge; otherwise a drain empties it. The top
    // only asserts load when the slot is empty or draining, so an
    // unconsumed beat is never overwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Payload and last flag change only on a load, which keeps them
    // stable for the whole time a beat waits on a stalled consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            out_last <= 1'b0;
        end else if (load) begin
            out_data <= load_data;
            out_last <= load_last;
        end
    end

endmodule

// File: rtl/stream_demux_1ton.sv
// ---------------------------------------------------------------------------
// stream_demux_1ton
//
// Purpose:
//   Registered 1-to-N stream demultiplexer with valid/ready on every port.
//   Each accepted input beat lands in the one-entry slot of the channel
//   picked by in_sel and appears there one clock later. With PKT_MODE=1 the
//   select is captured on a packet's first beat and held until in_last.
//   Beats addressed to a non-existent channel are accepted and discarded,
//   and counted in a saturating drop counter.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   in_valid    input beat present
//   in_ready    input beat accepted when in_valid & in_ready
//   in_data     input payload
//   in_sel      destination channel (ignored while a packet is locked)
//   in_last     final beat of a packet
//   out_valid   per-channel beat present
//   out_ready   per-channel consumer ready
//   out_data    channel k payload at [k*DATA_W +: DATA_W]
//   out_last    per-channel last flag
//   drop_pulse  one-cycle pulse after a beat was discarded
//   drop_count  discarded-beat count, saturating
// ---------------------------------------------------------------------------
module stream_demux_1ton
    import stream_demux_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int N_CH     = 4,
    parameter  int PKT_MODE = 1,
    localparam int SEL_W    = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_last,
    output logic [N_CH-1:0]        out_valid,
    input  logic [N_CH-1:0]        out_ready,
    output logic [N_CH*DATA_W-1:0] out_data,
    output logic [N_CH-1:0]        out_last,
    output logic                   drop_pulse,
    output logic [DROP_CNT_W-1:0]  drop_count
);

    logic [0:0]            state_q;
    logic [0:0]            state_d;
    logic [SEL_W-1:0]      lock_sel_q;
    logic [SEL_W-1:0]      eff_sel;
    logic                  sel_valid;
    logic [N_CH-1:0]       ch_hit;
    logic [N_CH-1:0]       slot_load;
    logic                  accept;
    logic                  drop;
    logic                  drop_pulse_q;
    logic [DROP_CNT_W-1:0] drop_count_q;

    // While a packet is locked the captured select steers the beat and
    // in_sel is ignored.
    assign eff_sel = (state_q == ST_LOCKED) ? lock_sel_q : in_sel;

    // Widen by one bit so the comparison still works when N_CH is a power
    // of two and N_CH itself does not fit in SEL_W bits.
    assign sel_valid = ({1'b0, eff_sel} < (SEL_W + 1)'(N_CH));

    // One-hot channel decode; it is all-zero for an invalid select, so no
    // per-channel vector is ever indexed out of range.
    for (genvar k = 0; k < N_CH; k++) begin : g_hit
        assign ch_hit[k] = (eff_sel == SEL_W'(k));
    end

    // Ready depends only on the FSM, the slots and the consumers, never on
    // in_valid. A discard target is always ready; a real channel is ready
    // when its slot is empty or draining this cycle.
    assign in_ready  = ~sel_valid | (|(ch_hit & (~out_valid | out_ready)));
    assign accept    = in_valid & in_ready;
    assign slot_load = {N_CH{accept}} & ch_hit;
    assign drop      = accept & ~sel_valid;

    // Output slots, one per channel, flattened onto the output buses.
    for (genvar k = 0; k < N_CH; k++) begin : g_slot
        demux_out_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (slot_load[k]),
            .load_data (in_data),
            .load_last (in_last),
            .out_ready (out_ready[k]),
            .out_valid (out_valid[k]),
            .out_data  (out_data[k*DATA_W +: DATA_W]),
            .out_last  (out_last[k])
        );
    end

    // Packet FSM. A multi-beat packet starts on an accepted beat without
    // in_last and ends on an accepted beat with it; a single-beat packet
    // never leaves IDLE. In beat mode the FSM is parked in IDLE.
    always_comb begin
        state_d = state_q;
        if ((PKT_MODE != 0) && accept) begin
            if ((state_q == ST_IDLE) && !in_last) begin
                state_d = ST_LOCKED;
            end else if ((state_q == ST_LOCKED) && in_last) begin
                state_d = ST_IDLE;
            end
        end
    end

    // State register and select capture. The select is captured raw, so a
    // packet addressed to a missing channel stays locked onto it and every
    // beat up to in_last is discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            lock_sel_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && (state_d == ST_LOCKED)) begin
                lock_sel_q <= in_sel;
            end
        end
    end

    // Drop reporting: a one-cycle pulse after each discarded beat and a
    // counter that sticks at its maximum instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_pulse_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            drop_pulse_q <= drop;
            if (drop) begin
                drop_count_q <= sat_inc(drop_count_q);
            end
        end
    end

    assign drop_pulse = drop_pulse_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_stream_demux_1ton.sv
// ---------------------------------------------------------------------------
// tb_stream_demux_1ton
//
// Purpose:
//   Directed self-checking bench for stream_demux_1ton. Three instances
//   share clock and reset:
//     dut0  N_CH=4, PKT_MODE=0  (beat routing, back-pressure)
//     dut1  N_CH=4, PKT_MODE=1  (packet lock, reset mid-packet)
//     dut2  N_CH=3, PKT_MODE=1  (invalid select, drop counter saturation)
// ---------------------------------------------------------------------------
module tb_stream_demux_1ton;
    import stream_demux_pkg::*;

    logic clk = 1'b0;
    logic rst;

    logic        a_in_valid, a_in_ready, a_in_last, a_drop_pulse;
    logic [7:0]  a_in_data;
    logic [1:0]  a_in_sel;
    logic [3:0]  a_out_valid, a_out_ready, a_out_last;
    logic [31:0] a_out_data;
    logic [15:0] a_drop_count;

    logic        b_in_valid, b_in_ready, b_in_last, b_drop_pulse;
    logic [7:0]  b_in_data;
    logic [1:0]  b_in_sel;
    logic [3:0]  b_out_valid, b_out_ready, b_out_last;
    logic [31:0] b_out_data;
    logic [15:0] b_drop_count;

    logic        c_in_valid, c_in_ready, c_in_last, c_drop_pulse;
    logic [7:0]  c_in_data;
    logic [1:0]  c_in_sel;
    logic [2:0]  c_out_valid, c_out_ready, c_out_last;
    logic [23:0] c_out_data;
    logic [15:0] c_drop_count;

    int assertions_evaluated = 0;
    int failures = 0;

    // 100 MHz style free-running clock.
    always #5 clk = ~clk;

    stream_demux_1ton #(.DATA_W(8), .N_CH(4), .PKT_MODE(0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_sel(a_in_sel), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_last(a_out_last), .drop_pulse(a_drop_pulse), .drop_count(a_drop_count)
    );

    stream_demux_1ton #(.DATA_W(8), .N_CH(4), .PKT_MODE(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_sel(b_in_sel), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_last(b_out_last), .drop_pulse(b_drop_pulse), .drop_count(b_drop_count)
    );

    stream_demux_1ton #(.DATA_W(8), .N_CH(3), .PKT_MODE(1)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .in_sel(c_in_sel), .in_last(c_in_last),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .out_last(c_out_last), .drop_pulse(c_drop_pulse), .drop_count(c_drop_count)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertions_evaluated++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive the input side of one instance (0 = dut0, 1 = dut1, 2 = dut2).
    task automatic applyStimulus(input int which, input logic valid, input logic [1:0] sel,
                                 input logic [7:0] data, input logic last);
        case (which)
            0: begin a_in_valid = valid; a_in_sel = sel; a_in_data = data; a_in_last = last; end
            1: begin b_in_valid = valid; b_in_sel = sel; b_in_data = data; b_in_last = last; end
            default: begin c_in_valid = valid; c_in_sel = sel; c_in_data = data; c_in_last = last; end
        endcase
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hard stop in case the sequence below ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, limit 100000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(0, 1'b0, 2'd0, 8'h00, 1'b0);
        applyStimulus(1, 1'b0, 2'd0, 8'h00, 1'b0);
        applyStimulus(2, 1'b0, 2'd0, 8'h00, 1'b0);
        a_out_ready = 4'b1111;
        b_out_ready = 4'b1111;
        c_out_ready = 3'b111;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(a_out_valid), 32'h0);
        checkOutput("rst_out_data", a_out_data, 32'h0);
        checkOutput("rst_out_last", 32'(b_out_last), 32'h0);
        checkOutput("rst_drop_pulse", 32'(c_drop_pulse), 32'h0);
        checkOutput("rst_drop_count", 32'(c_drop_count), 32'h0);
        checkOutput("rst_in_ready", 32'(a_in_ready), 32'h1);
        rst = 1'b0;
        tick();

        // Beat mode: one beat to each channel, visible one cycle later.
        $display("[TB] beat routing");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1'b1, 2'(k), 8'(8'hA0 + k), 1'b0);
            #1;
            checkOutput($sformatf("t1_in_ready_%0d", k), 32'(a_in_ready), 32'h1);
            tick();
            checkOutput($sformatf("t1_out_valid_%0d", k), 32'(a_out_valid), 32'(4'b0001 << k));
            checkOutput($sformatf("t1_out_data_%0d", k), 32'(a_out_data[k*8 +: 8]), 32'(8'hA0 + k));
        end
        applyStimulus(0, 1'b0, 2'd0, 8'h00, 1'b0);
        tick();
        checkOutput("t1_drained", 32'(a_out_valid), 32'h0);

        // Back-pressure on channel 2.
        $display("[TB] back-pressure");
        a_out_ready = 4'b1011;
        applyStimulus(0, 1'b1, 2'd2, 8'hB0, 1'b0);
        #1;
        checkOutput("t2_ready_first", 32'(a_in_ready), 32'h1);
        tick();
        checkOutput("t2_valid_first", 32'(a_out_valid), 32'b0100);
        checkOutput("t2_data_first", 32'(a_out_data[23:16]), 32'hB0);
        applyStimulus(0, 1'b0, 2'd0, 8'h00, 1'b0);
        #1;
        checkOutput("t2_ready_other_ch", 32'(a_in_ready), 32'h1);
        applyStimulus(0, 1'b1, 2'd2, 8'hB1, 1'b0);
        #1;
        checkOutput("t2_ready_blocked", 32'(a_in_ready), 32'h0);
        tick();
        checkOutput("t2_data_held", 32'(a_out_data[23:16]), 32'hB0);
        checkOutput("t2_valid_held", 32'(a_out_valid), 32'b0100);
        a_out_ready = 4'b1111;
        #1;
        checkOutput("t2_ready_release", 32'(a_in_ready), 32'h1);
        tick();
        checkOutput("t2_valid_second", 32'(a_out_valid), 32'b0100);
        checkOutput("t2_data_second", 32'(a_out_data[23:16]), 32'hB1);
        applyStimulus(0, 1'b0, 2'd0, 8'h00, 1'b0);
        tick();
        checkOutput("t2_drained", 32'(a_out_valid), 32'h0);

        // Packet mode: select locked to channel 1 despite in_sel changing.
        $display("[TB] packet lock");
        applyStimulus(1, 1'b1, 2'd1, 8'hC1, 1'b0);
        tick();
        checkOutput("t3_valid_b1", 32'(b_out_valid), 32'b0010);
        checkOutput("t3_data_b1", 32'(b_out_data[15:8]), 32'hC1);
        checkOutput("t3_last_b1", 32'(b_out_last), 32'h0);
        checkOutput("t3_state_locked", 32'(dut1.state_q), 32'(ST_LOCKED));
        applyStimulus(1, 1'b1, 2'd3, 8'hC2, 1'b0);
        tick();
        checkOutput("t3_valid_b2", 32'(b_out_valid), 32'b0010);
        checkOutput("t3_data_b2", 32'(b_out_data[15:8]), 32'hC2);
        applyStimulus(1, 1'b1, 2'd3, 8'hC3, 1'b1);
        tick();
        checkOutput("t3_valid_b3", 32'(b_out_valid), 32'b0010);
        checkOutput("t3_data_b3", 32'(b_out_data[15:8]), 32'hC3);
        checkOutput("t3_last_b3", 32'(b_out_last), 32'b0010);
        checkOutput("t3_state_idle", 32'(dut1.state_q), 32'(ST_IDLE));
        applyStimulus(1, 1'b1, 2'd3, 8'hD3, 1'b1);
        tick();
        checkOutput("t3_unlocked_ch3", 32'(b_out_valid), 32'b1000);
        checkOutput("t3_unlocked_data", 32'(b_out_data[31:24]), 32'hD3);
        applyStimulus(1, 1'b0, 2'd0, 8'h00, 1'b0);
        tick();

        // Invalid select on a 3-channel instance: whole packet discarded.
        $display("[TB] invalid select drop");
        applyStimulus(2, 1'b1, 2'd3, 8'hE0, 1'b0);
        #1;
        checkOutput("t4_ready_invalid", 32'(c_in_ready), 32'h1);
        tick();
        checkOutput("t4_valid_b1", 32'(c_out_valid), 32'h0);
        checkOutput("t4_pulse_b1", 32'(c_drop_pulse), 32'h1);
        checkOutput("t4_count_b1", 32'(c_drop_count), 32'd1);
        applyStimulus(2, 1'b1, 2'd0, 8'hE1, 1'b1);
        tick();
        checkOutput("t4_valid_b2", 32'(c_out_valid), 32'h0);
        checkOutput("t4_pulse_b2", 32'(c_drop_pulse), 32'h1);
        checkOutput("t4_count_b2", 32'(c_drop_count), 32'd2);
        applyStimulus(2, 1'b0, 2'd0, 8'h00, 1'b0);
        tick();
        checkOutput("t4_pulse_end", 32'(c_drop_pulse), 32'h0);
        checkOutput("t4_count_end", 32'(c_drop_count), 32'd2);

        // Drop counter saturation from a preloaded value.
        $display("[TB] drop counter saturation");
        force dut2.drop_count_q = 16'hFFFE;
        tick();
        release dut2.drop_count_q;
        #1;
        checkOutput("t5_preload", 32'(c_drop_count), 32'hFFFE);
        applyStimulus(2, 1'b1, 2'd3, 8'h55, 1'b1);
        tick();
        checkOutput("t5_count_1", 32'(c_drop_count), 32'hFFFF);
        tick();
        checkOutput("t5_count_2", 32'(c_drop_count), 32'hFFFF);
        checkOutput("t5_pulse_2", 32'(c_drop_pulse), 32'h1);
        tick();
        checkOutput("t5_count_3", 32'(c_drop_count), 32'hFFFF);
        applyStimulus(2, 1'b0, 2'd0, 8'h00, 1'b0);
        tick();
        checkOutput("t5_count_final", 32'(c_drop_count), 32'hFFFF);

        // Reset during a locked packet with full slots.
        $display("[TB] reset mid-packet");
        b_out_ready = 4'b0000;
        applyStimulus(1, 1'b1, 2'd0, 8'hF0, 1'b1);
        tick();
        applyStimulus(1, 1'b1, 2'd2, 8'hF2, 1'b0);
        tick();
        applyStimulus(1, 1'b0, 2'd0, 8'h00, 1'b0);
        checkOutput("t6_full", 32'(b_out_valid), 32'b0101);
        checkOutput("t6_locked", 32'(dut1.state_q), 32'(ST_LOCKED));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_async_valid", 32'(b_out_valid), 32'h0);
        checkOutput("t6_async_data", b_out_data, 32'h0);
        checkOutput("t6_async_state", 32'(dut1.state_q), 32'(ST_IDLE));
        tick();
        rst = 1'b0;
        b_out_ready = 4'b1111;
        applyStimulus(1, 1'b1, 2'd0, 8'h5A, 1'b1);
        tick();
        checkOutput("t6_after_valid", 32'(b_out_valid), 32'b0001);
        checkOutput("t6_after_data", 32'(b_out_data[7:0]), 32'h5A);
        applyStimulus(1, 1'b0, 2'd0, 8'h00, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertions_evaluated, failures);
        $finish;
    end

endmodule
